// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order reorder stage behind a radix-2 DIF FFT.
// Two-sample input beats fill a ping-pong buffer that drains one bin per cycle.

module fft_bitrev_bank #(
    parameter int AW = 6,
    parameter int WW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [WW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [WW-1:0] rd_data
);
    logic [WW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read register doubles as the output register; it only moves on rd_en.
    always_ff @(posedge clk) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

module fft_bitrev_reorder #(
    parameter int N     = 64,
    parameter int LOG2N = 6,
    parameter int DW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_start,
    input  logic [DW-1:0]    in_re0,
    input  logic [DW-1:0]    in_im0,
    input  logic [DW-1:0]    in_re1,
    input  logic [DW-1:0]    in_im1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_re,
    output logic [DW-1:0]    out_im,
    output logic [LOG2N-1:0] out_index,
    output logic             out_last,
    output logic             drop
);
    localparam int HW        = LOG2N - 1;
    localparam int NUM_LANES = 2;  // lane 0 = lo half (bins 0..N/2-1), lane 1 = hi half
    localparam int VEC_W     = 2 * DW;
    localparam logic [HW-1:0]    BEAT_LAST = '1;
    localparam logic [LOG2N-1:0] BIN_LAST  = '1;

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} buf_state_e;
    typedef enum logic {W_IDLE, W_FILL}  wstate_e;
    typedef enum logic {R_IDLE, R_DRAIN} rstate_e;

    typedef struct packed {
        logic                            en;
        logic [HW:0]                     addr;  // {buffer, entry}
        logic [NUM_LANES-1:0][VEC_W-1:0] data;
    } wr_req_t;

    function automatic logic [HW-1:0] bitrev(input logic [HW-1:0] v);
        logic [HW-1:0] r;
        for (int i = 0; i < HW; i++) r[i] = v[HW-1-i];
        return r;
    endfunction

    buf_state_e bstate [2];
    logic       last_full;
    logic       any_empty, empty_sel, full_any, full_sel;

    wstate_e       wstate, wstate_n;
    logic          wbuf, wbuf_n;
    logic [HW-1:0] wcnt, wcnt_n;
    logic          w_claim, w_restart, w_beat, w_done, w_drop;
    wr_req_t       wr;

    rstate_e          rstate, rstate_n;
    logic             rbuf, rbuf_n;
    logic [LOG2N-1:0] rcnt, rcnt_n;
    logic             hs, r_start, r_first, r_step, r_end, r_chain, rd_en;
    logic [HW:0]      rd_addr;
    logic [NUM_LANES-1:0][VEC_W-1:0] rd_data;

    assign any_empty = (bstate[0] == B_EMPTY) || (bstate[1] == B_EMPTY);
    assign empty_sel = (bstate[0] != B_EMPTY);
    assign full_any  = (bstate[0] == B_FULL) || (bstate[1] == B_FULL);
    assign full_sel  = (bstate[0] == B_FULL && bstate[1] == B_FULL) ? ~last_full
                                                                      : (bstate[1] == B_FULL);

    assign w_restart = in_valid && in_start && wstate == W_FILL;
    assign w_claim   = in_valid && in_start && wstate == W_IDLE && any_empty;
    assign w_drop    = in_valid && in_start && wstate == W_IDLE && !any_empty;
    assign w_beat    = in_valid && !in_start && wstate == W_FILL;
    assign w_done    = w_beat && wcnt == BEAT_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate <= W_IDLE;
            wbuf   <= 1'b0;
            wcnt   <= '0;
            drop   <= 1'b0;
        end else begin
            wstate <= wstate_n;
            wbuf   <= wbuf_n;
            wcnt   <= wcnt_n;
            drop   <= w_drop;
        end
    end

    always_comb begin
        wstate_n = wstate;
        wbuf_n   = wbuf;
        wcnt_n   = wcnt;
        if (w_claim || w_restart) begin
            wstate_n = W_FILL;
            wcnt_n   = HW'(1);
            if (w_claim) wbuf_n = empty_sel;
        end else if (w_beat) begin
            wcnt_n = wcnt + HW'(1);
            if (w_done) wstate_n = W_IDLE;
        end
    end

    always_comb begin
        wr      = '0;
        wr.en   = w_claim || w_restart || w_beat;
        wr.addr = {w_claim ? empty_sel : wbuf, bitrev(w_beat ? wcnt : '0)};
        wr.data = {{in_re1, in_im1}, {in_re0, in_im0}};
    end

    // Writer and reader never own the same buffer, so their updates cannot collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            bstate[0] <= B_EMPTY;
            bstate[1] <= B_EMPTY;
            last_full <= 1'b0;
        end else begin
            if (w_claim) bstate[empty_sel] <= B_FILLING;
            if (w_done) begin
                bstate[wbuf] <= B_FULL;
                last_full    <= wbuf;
            end
            if (r_start) bstate[full_sel] <= B_DRAINING;
            if (r_end)   bstate[rbuf]     <= B_EMPTY;
            if (r_chain) bstate[~rbuf]    <= B_DRAINING;
        end
    end

    assign hs      = out_valid && out_ready;
    assign r_start = rstate == R_IDLE && full_any;
    assign r_first = rstate == R_DRAIN && !out_valid;
    assign r_step  = hs && rcnt != BIN_LAST;
    assign r_end   = hs && rcnt == BIN_LAST;
    assign r_chain = r_end && bstate[~rbuf] == B_FULL;

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate    <= R_IDLE;
            rbuf      <= 1'b0;
            rcnt      <= '0;
            out_valid <= 1'b0;
        end else begin
            rstate    <= rstate_n;
            rbuf      <= rbuf_n;
            rcnt      <= rcnt_n;
            out_valid <= rd_en || (out_valid && !hs);
        end
    end

    always_comb begin
        rstate_n = rstate;
        rbuf_n   = rbuf;
        rcnt_n   = rcnt;
        if (r_start) begin
            rstate_n = R_DRAIN;
            rbuf_n   = full_sel;
            rcnt_n   = '0;
        end else if (r_step) begin
            rcnt_n = rcnt + LOG2N'(1);
        end else if (r_end) begin
            rcnt_n = '0;
            if (r_chain) rbuf_n   = ~rbuf;
            else         rstate_n = R_IDLE;
        end
    end

    // Address the RAM with the next bin so the registered read lands with no bubble.
    always_comb begin
        rd_en   = r_first || r_step || r_chain;
        rd_addr = {rbuf_n, rcnt_n[HW-1:0]};
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        fft_bitrev_bank #(.AW(HW + 1), .WW(VEC_W)) u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr.en),
            .wr_addr (wr.addr),
            .wr_data (wr.data[l]),
            .rd_en   (rd_en),
            .rd_addr (rd_addr),
            .rd_data (rd_data[l])
        );
    end

    assign out_re    = rd_data[rcnt[LOG2N-1]][VEC_W-1:DW];
    assign out_im    = rd_data[rcnt[LOG2N-1]][DW-1:0];
    assign out_index = rcnt;
    assign out_last  = out_valid && rcnt == BIN_LAST;
endmodule
